// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-select
// arbitration, packet locking on multi-beat packets, and a registered output stage.
module stream_mux_rr #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  fixed_mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;

  logic               rr_found;
  logic [SEL_W-1:0]   rr_ch;
  logic [SEL_W-1:0]   idx_sel;
  logic               sel_in_range;
  logic               grant_ok;
  logic [SEL_W-1:0]   grant_ch;
  logic               can_load;
  logic               xfer;
  logic [WIDTH-1:0]   beat_data;
  logic               beat_last;

  // Round-robin search starts one past the channel that last finished a packet.
  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    idx_sel  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx_sel = SEL_W'((int'(rr_ptr_q) + k) % N_CH);
      if (!rr_found && in_valid[idx_sel]) begin
        rr_found = 1'b1;
        rr_ch    = idx_sel;
      end
    end
  end

  assign sel_in_range = (int'(sel) < N_CH);

  always_comb begin
    grant_ok = 1'b0;
    grant_ch = '0;
    if (state_q == LOCKED) begin
      grant_ok = 1'b1;
      grant_ch = lock_ch_q;
    end else if (fixed_mode) begin
      grant_ok = sel_in_range;
      grant_ch = sel;
    end else begin
      grant_ok = rr_found;
      grant_ch = rr_ch;
    end
  end

  assign can_load  = !out_valid_q || out_ready;
  assign xfer      = !rst && grant_ok && can_load && in_valid[grant_ch];
  assign beat_data = in_data[int'(grant_ch)*WIDTH +: WIDTH];
  assign beat_last = in_last[grant_ch];

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = !rst && grant_ok && can_load && (grant_ch == SEL_W'(i));
    end
  end

  // Packet boundaries drive the lock and the fairness pointer; nothing else does.
  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_data_d  = beat_data;
      out_last_d  = beat_last;
      out_ch_d    = grant_ch;
      out_valid_d = 1'b1;
      if (beat_last) begin
        state_d  = IDLE;
        rr_ptr_d = grant_ch;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = grant_ch;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Table-driven bench for stream_mux_rr: each row gives inputs plus expected
// in_ready/out_valid; accepted beats go to a scoreboard checked at the output.
module tb_stream_mux_rr;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  logic                  fixed_mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_last;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;

  stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .fixed_mode(fixed_mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        fixed;
    logic [1:0]  sel;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [1:0] ch;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic void addRow(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                 input logic f, input logic [1:0] s, input logic o,
                                 input logic [3:0] er, input logic eov);
    vec_t r;
    r.valid = v; r.last = l; r.data = d; r.fixed = f; r.sel = s; r.ordy = o;
    r.exp_rdy = er; r.exp_ov = eov;
    vecs.push_back(r);
  endfunction

  task automatic setInputs(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                           input logic f, input logic [1:0] s, input logic o);
    in_valid = v; in_last = l; in_data = d; fixed_mode = f; sel = s; out_ready = o;
  endtask

  // Compares the registered output against the scoreboard head and enqueues
  // the beat the row expects to be accepted at the coming edge.
  task automatic checkOutput(input vec_t r, input int idx);
    beat_t b;
    check($sformatf("row%0d_in_ready", idx), 32'(in_ready), 32'(r.exp_rdy));
    check($sformatf("row%0d_out_valid", idx), 32'(out_valid), 32'(r.exp_ov));
    if (out_valid === 1'b1) begin
      check($sformatf("row%0d_sb_nonempty", idx), 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        b = sb[0];
        check($sformatf("row%0d_out_data", idx), 32'(out_data), 32'(b.data));
        check($sformatf("row%0d_out_last", idx), 32'(out_last), 32'(b.last));
        check($sformatf("row%0d_out_ch", idx), 32'(out_ch), 32'(b.ch));
        if (r.ordy) void'(sb.pop_front());
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (r.exp_rdy[i] && r.valid[i]) begin
        b.data = r.data[i*8 +: 8];
        b.last = r.last[i];
        b.ch   = 2'(i);
        sb.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t r, input int idx);
    @(negedge clk);
    setInputs(r.valid, r.last, r.data, r.fixed, r.sel, r.ordy);
    #1 checkOutput(r, idx);
  endtask

  initial begin
    // Idle after reset
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 0);
    // Round-robin fairness, single-beat packets
    addRow(4'hF, 4'hF, 32'h43322110, 0, 0, 1, 4'h1, 0);
    addRow(4'hF, 4'hF, 32'h43322110, 0, 0, 1, 4'h2, 1);
    addRow(4'hF, 4'hF, 32'h43322110, 0, 0, 1, 4'h4, 1);
    addRow(4'hF, 4'hF, 32'h43322110, 0, 0, 1, 4'h8, 1);
    addRow(4'hF, 4'hF, 32'h43322110, 0, 0, 1, 4'h1, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 0);
    // Packet lock on ch1 while ch2 waits, then ch1 regains its turn
    addRow(4'h6, 4'h4, 32'h0055AA00, 0, 0, 1, 4'h2, 0);
    addRow(4'h6, 4'h4, 32'h0055BB00, 0, 0, 1, 4'h2, 1);
    addRow(4'h6, 4'h6, 32'h0055CC00, 0, 0, 1, 4'h2, 1);
    addRow(4'h6, 4'h6, 32'h0055DD00, 0, 0, 1, 4'h4, 1);
    addRow(4'h2, 4'h2, 32'h0000DD00, 0, 0, 1, 4'h2, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 0);
    // Backpressure: 77 held for 3 cycles, then drains as 88 loads
    addRow(4'h8, 4'h8, 32'h77000000, 0, 0, 1, 4'h8, 0);
    addRow(4'h1, 4'h1, 32'h00000088, 0, 0, 0, 4'h0, 1);
    addRow(4'h1, 4'h1, 32'h00000088, 0, 0, 0, 4'h0, 1);
    addRow(4'h1, 4'h1, 32'h00000088, 0, 0, 0, 4'h0, 1);
    addRow(4'h1, 4'h1, 32'h00000088, 0, 0, 1, 4'h1, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 0);
    // Fixed mode: sel=3 served, sel=2 idle, sel/mode changes ignored mid-packet
    addRow(4'h9, 4'h9, 32'hE30000E0, 1, 3, 1, 4'h8, 0);
    addRow(4'h9, 4'h9, 32'hE40000E0, 1, 3, 1, 4'h8, 1);
    addRow(4'h9, 4'h9, 32'hE40000E0, 1, 2, 1, 4'h4, 1);
    addRow(4'h9, 4'h9, 32'hE40000E0, 1, 2, 1, 4'h4, 0);
    addRow(4'h9, 4'h1, 32'hF00000E0, 1, 3, 1, 4'h8, 0);
    addRow(4'h9, 4'h1, 32'hF10000E0, 1, 0, 1, 4'h8, 1);
    addRow(4'h1, 4'h1, 32'h000000E0, 1, 0, 1, 4'h8, 1);
    addRow(4'h9, 4'h9, 32'hF20000E0, 0, 0, 1, 4'h8, 0);
    addRow(4'h9, 4'h9, 32'hF20000E0, 1, 0, 1, 4'h1, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 1);
    addRow(4'h0, 4'h0, 32'h0, 0, 0, 1, 4'h0, 0);
    // Open a packet on ch2 ahead of the mid-packet reset
    addRow(4'h4, 4'h0, 32'h002A0000, 1, 2, 1, 4'h4, 0);

    rst = 1'b1;
    setInputs(4'hF, 4'hF, 32'h43322110, 0, 0, 1);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    @(negedge clk);
    setInputs(4'h0, 4'h0, 32'h0, 0, 0, 1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Mid-cycle reset while locked on ch2 with the first beat on the output
    @(negedge clk);
    setInputs(4'h0, 4'h0, 32'h0, 0, 0, 1);
    #1;
    check("prerst_out_valid", 32'(out_valid), 32'h1);
    check("prerst_out_data", 32'(out_data), 32'h2A);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_data", 32'(out_data), 32'h0);
    check("midrst_out_ch", 32'(out_ch), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    sb.delete();
    #1 rst = 1'b0;

    applyStimulus('{valid:4'hF, last:4'hF, data:32'h43322110, fixed:1'b0, sel:2'd0,
                    ordy:1'b1, exp_rdy:4'h1, exp_ov:1'b0}, 100);
    applyStimulus('{valid:4'h0, last:4'h0, data:32'h0, fixed:1'b0, sel:2'd0,
                    ordy:1'b1, exp_rdy:4'h0, exp_ov:1'b1}, 101);
    applyStimulus('{valid:4'h0, last:4'h0, data:32'h0, fixed:1'b0, sel:2'd0,
                    ordy:1'b1, exp_rdy:4'h0, exp_ov:1'b0}, 102);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit streaming multiplexer. Generalises the basic 2:1 combinational mux.
- Each input channel has a valid/ready handshake. Channel choice is either round-robin arbitration or a fixed external select.
- Once a packet starts (a beat with last=0), the channel is locked until that packet ends.
- The output is registered and sustains one beat per cycle. It feeds shared downstream datapaths (UART/FIFO/bus front-ends) from several producers.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- SEL_W (localparam), $clog2(N_CH), width of channel index signals.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_data  input  N_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel valid
- in_last  input  N_CH  per-channel end-of-packet marker, qualified by valid
- in_ready  output  N_CH  per-channel ready, combinational
- fixed_mode  input  1  1 = use sel; 0 = round-robin
- sel  input  SEL_W  channel select when fixed_mode=1
- out_data  output  WIDTH  registered data
- out_valid  output  1  registered valid
- out_last  output  1  registered last
- out_ch  output  SEL_W  source channel of the current output beat
- out_ready  input  1  downstream ready

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr_ptr=N_CH-1 (so channel 0 has first priority). in_ready is combinational; it is all-0 while rst=1.
- States:
  - IDLE: no packet open.
  - LOCKED: packet open on lock_ch.
- Grant in IDLE:
  - fixed_mode=1: grant=sel. If sel>=N_CH, there is no grant.
  - fixed_mode=0: grant is the first channel with in_valid=1, searching rr_ptr+1, rr_ptr+2, ... modulo N_CH. If no channel is valid, there is no grant.
- Grant in LOCKED: grant=lock_ch, regardless of fixed_mode, sel, or other channels' valids.
- Ready:
  - can_load = !out_valid | out_ready.
  - in_ready[i] = can_load & grant exists & (i==grant). All other in_ready bits are 0.
- Transfer: a transfer occurs on channel g when in_valid[g] & in_ready[g] at a rising edge. On that edge:
  - out_data <= channel g data; out_last <= in_last[g]; out_ch <= g; out_valid <= 1.
- Drain: if out_valid & out_ready and there is no transfer, out_valid <= 0. out_data, out_last and out_ch hold their values.
- Stall: if out_valid & !out_ready, all output registers hold and in_ready is all-0.
- Latency and throughput: one cycle from input transfer to out_valid. With out_ready held at 1, throughput is 1 beat/cycle, including back-to-back beats from different channels.
- State transitions, evaluated on a transfer only:
  - IDLE, last=0 -> LOCKED with lock_ch=g.
  - IDLE, last=1 -> stay IDLE, rr_ptr<=g.
  - LOCKED, last=1 -> IDLE, rr_ptr<=g.
  - LOCKED, last=0 -> stay LOCKED.
- rr_ptr updates only at packet end, in both modes.
- Locked channel going idle: if lock_ch deasserts valid while LOCKED, the block waits. No other channel is served.
- Mode or select change while LOCKED: changes to fixed_mode or sel take effect only after the packet ends.
- Reset mid-packet: the lock is dropped, the output beat is discarded (out_valid=0), and rr_ptr returns to N_CH-1.
- Width rules: out_ch is zero-extended to SEL_W. There is no data transformation.

Test Plan:
- Reset and idle: N_CH=4, WIDTH=8. Assert rst mid-cycle -> outputs clear immediately, without waiting for a clock edge. After release with no valids -> out_valid=0 and in_ready=0000.
- Round-robin fairness: channels 0..3 all valid with single-beat packets (last=1), data 8'h10,8'h21,8'h32,8'h43, out_ready=1 -> out_ch sequence 0,1,2,3,0, one beat per cycle, out_valid continuous.
- Packet lock: channel 1 sends 3 beats (AA, BB, CC; last only on CC) while channel 2 is valid with 8'h55 -> output AA, BB, CC from ch1, then 55 from ch2. in_ready[2]=0 until the cycle after CC is accepted.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and data 8'h77 -> out_data stays 77 and in_ready=0000. Raise out_ready -> 77 drains and the next beat loads in the same cycle.
- Fixed mode: fixed_mode=1, sel=3, channels 0 and 3 valid -> only channel 3 is served. sel=2 with channel 2 idle -> no transfer. sel changed mid-packet -> ignored until last.
- Reset mid-packet: rst pulse while LOCKED on ch2 after 1 beat -> out_valid=0 and state IDLE. Next grant with all channels valid -> channel 0.
